aec: RTL and testbench
======================

// Module: aec
// PURPOSE
// - Arithmetic Expression Calculator. Accepts one infix expression as a serial
//   ASCII character stream, one character per clock, and returns its 7-bit value.
// - Standalone compute block. An upstream character source feeds it; the
//   consumer samples result on the single-cycle valid pulse.
// - Internally: shunting-yard infix->postfix during input, then postfix evaluation.
// PARAMETERS
// - MAX_LEN  16  maximum expression characters, including the trailing '='
// - DW       16  internal signed datapath width (two's complement)
// PORTS
// - clk       input   1  clock; all state updates on the rising edge
// - rst       input   1  reset; asynchronous, active-low
// - ready     input   1  one-cycle pulse; qualifies the first character of an expression
// - ascii_in  input   8  character in; one new character every cycle, starting with ready
// - valid     output  1  one-cycle pulse; result holds the answer
// - result    output  7  expression value
// BEHAVIOUR
// - Reset (rst low, asynchronous):
//   - valid=0, result=0; all stacks/buffers empty; FSM goes to IDLE.
//   - Reset mid-expression aborts that expression. No valid is produced for it.
// - Character set:
//   - '0'-'9' (0x30-0x39) = 0-9; 'a'-'f' (0x61-0x66) = 10-15.
//   - Operands are single characters.
//   - Operators: '+' 0x2B, '-' 0x2D, '*' 0x2A. Brackets: '(' 0x28, ')' 0x29.
//   - '=' 0x3D terminates the expression.
//   - Any other code is ignored. It consumes its cycle and has no effect.
// - Input protocol:
//   - The character on the cycle ready=1 is character 0.
//   - Characters 1..n follow on consecutive cycles with no gaps.
//   - ready stays 0 while characters 1..n arrive. The last character is '='.
//   - ascii_in is ignored from the cycle after '=' until valid has pulsed.
// - FSM states: IDLE -> READ -> FLUSH -> EVAL -> OUT -> IDLE.
//   - IDLE: wait for ready=1; process its character; go to READ.
//   - READ, operand: appended to the postfix queue.
//   - READ, '(': pushed onto the operator stack.
//   - READ, ')': pop operators to the queue until '('; discard the '('.
//   - READ, operator: pop to the queue while stack top is an operator of >= precedence
//     ('*' > '+' = '-'; left associative), one pop per cycle; then push.
//     Input is not stalled. Implement the pops combinationally or with an input FIFO,
//     so no character is lost.
//   - READ, '=': go to FLUSH.
//   - FLUSH: pop the remaining operators to the queue; then go to EVAL.
//   - EVAL: scan the queue one token per cycle on a value stack.
//     Operand -> push. Operator -> pop b, pop a, push a op b.
//   - OUT: result <= final stack value [6:0]; valid=1 for exactly one cycle; go to IDLE.
// - Arithmetic:
//   - All operations are DW-bit signed; subtraction may go negative.
//   - result is the low 7 bits (value mod 128).
//   - Multiplication keeps the low DW bits.
// - Latency: valid rises at most 2*MAX_LEN+4 cycles after the '=' cycle.
// - The next ready is accepted from the cycle after valid. result holds until the next valid.
// - Boundaries:
//   - Minimal expression "7=" is legal; result=7.
//   - Deepest nesting = MAX_LEN/2. Stacks sized MAX_LEN. No overflow for legal input.
//   - Malformed input (unbalanced brackets, overflow): valid still pulses within the
//     latency bound; result is undefined.
// CONFIGURATION
// - AEC_SAT_EN undefined: result = value[6:0] (wrap modulo 128).
// - AEC_SAT_EN defined: result saturates. Negative -> 0; >127 -> 127; else the value.
// TESTING
// - "1+2*3=" -> valid one cycle, result=7 (precedence)
// - "(1+2)*3=" -> result=9; then "a*b-5=" issued right after valid -> result=105 (hex digits, back-to-back)
// - "f*f=" -> result=97 (225 wrapped); with AEC_SAT_EN -> 127
// - "2-5=" -> result=125 (-3 wrapped); with AEC_SAT_EN -> 0
// - "((9-(2+3))*(4-1))-1=" -> result=11 (nesting, latency within bound)
// - rst low during "8*8+1=" -> no valid; after release "7=" -> result=7

Source files
------------

// File: rtl/aec.sv
// Arithmetic expression calculator: serial ASCII infix in, 7-bit value out.
// Latency: valid pulses at most 2*MAX_LEN+4 cycles after the '=' cycle.
// Backpressure: none. One character is consumed every cycle, and operator pops never stall input.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   ready     one-cycle pulse marking character 0 of an expression
//   ascii_in  character stream; one character per cycle starting with ready
//   valid     one-cycle pulse when result carries a new answer
//   result    low 7 bits of the value, or the saturated value when AEC_SAT_EN is defined
//
// Build option: define AEC_SAT_EN to clamp the result to 0..127 instead of wrapping it.
module aec #(
  parameter int MAX_LEN = 16,
  parameter int DW      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ready,
  input  logic [7:0] ascii_in,
  output logic       valid,
  output logic [6:0] result
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int PW = $clog2(MAX_LEN + 1);
  localparam logic [PW-1:0] DEPTH = PW'(MAX_LEN);
  localparam logic signed [DW-1:0] SAT_MAX = DW'(127);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_FLUSH, S_EVAL, S_OUT} state_t;
  typedef enum logic [1:0] {K_LP = 2'd0, K_ADD = 2'd1, K_SUB = 2'd2, K_MUL = 2'd3} opk_t;
  typedef enum logic [2:0] {C_IGN, C_NUM, C_OP, C_LP, C_RP, C_EQ} cls_t;

  // One postfix token: either a 4-bit operand or an arithmetic operator.
  typedef struct packed {
    logic       is_op;
    opk_t       op;
    logic [3:0] val;
  } tok_t;

  function automatic tok_t mk_num(input logic [3:0] v);
    tok_t t;
    t.is_op = 1'b0;
    t.op    = K_ADD;
    t.val   = v;
    return t;
  endfunction

  function automatic tok_t mk_op(input opk_t k);
    tok_t t;
    t.is_op = 1'b1;
    t.op    = k;
    t.val   = 4'd0;
    return t;
  endfunction

  state_t state;
  logic [PW-1:0] sp;    // operator stack depth
  logic [PW-1:0] qcnt;  // postfix queue fill
  logic [PW-1:0] rp;    // postfix read pointer during evaluation
  logic [PW-1:0] vsp;   // value stack depth

  opk_t                 opstk [MAX_LEN];
  tok_t                 q     [MAX_LEN];
  logic signed [DW-1:0] vs    [MAX_LEN];

  // Character decode
  cls_t       cls;
  logic [3:0] cval;
  opk_t       cop;

  always_comb begin
    cls  = C_IGN;
    cval = 4'd0;
    cop  = K_ADD;
    if (ascii_in >= 8'h30 && ascii_in <= 8'h39) begin
      cls  = C_NUM;
      cval = ascii_in[3:0];
    end else if (ascii_in >= 8'h61 && ascii_in <= 8'h66) begin
      cls  = C_NUM;
      cval = ascii_in[3:0] + 4'd9;
    end else begin
      case (ascii_in)
        8'h2B:   begin cls = C_OP; cop = K_ADD; end
        8'h2D:   begin cls = C_OP; cop = K_SUB; end
        8'h2A:   begin cls = C_OP; cop = K_MUL; end
        8'h28:   cls = C_LP;
        8'h29:   cls = C_RP;
        8'h3D:   cls = C_EQ;
        default: cls = C_IGN;
      endcase
    end
  end

  // Top three operator-stack entries. Within one bracket level the stack never
  // holds more than one additive operator with one '*' above it. So a single
  // incoming operator or ')' pops at most two operators, and ')' may then
  // discard a third entry, the '('. All of this is resolved in one cycle.
  opk_t top0, top1, top2;

  always_comb begin
    top0 = (sp >= PW'(1)) ? opstk[AW'(sp - PW'(1))] : K_LP;
    top1 = (sp >= PW'(2)) ? opstk[AW'(sp - PW'(2))] : K_LP;
    top2 = (sp >= PW'(3)) ? opstk[AW'(sp - PW'(3))] : K_LP;
  end

  logic          take;
  logic          pop0, pop1, push_en, push_wr, drop_lp, wr_opnd, go_flush;
  opk_t          push_k;
  logic [PW-1:0] sp_pop, sp_n;
  logic          qw0_en, qw1_en;
  tok_t          qw0, qw1;
  logic [PW-1:0] q1idx, qcnt_n;
  logic [PW:0]   qsum;

  assign take = (state == S_IDLE && ready) || (state == S_READ);

  always_comb begin
    pop0     = 1'b0;
    pop1     = 1'b0;
    push_en  = 1'b0;
    push_k   = K_LP;
    drop_lp  = 1'b0;
    wr_opnd  = 1'b0;
    go_flush = 1'b0;
    if (take) begin
      case (cls)
        C_NUM: wr_opnd = 1'b1;
        C_OP: begin
          // Left-associative pops: pop while top precedence >= incoming precedence.
          pop0 = (sp >= PW'(1)) && (top0 != K_LP) && (top0 == K_MUL || cop != K_MUL);
          pop1 = pop0 && (sp >= PW'(2)) && (top1 != K_LP) && (top1 == K_MUL || cop != K_MUL);
          push_en = 1'b1;
          push_k  = cop;
        end
        C_LP: begin
          push_en = 1'b1;
          push_k  = K_LP;
        end
        C_RP: begin
          pop0 = (sp >= PW'(1)) && (top0 != K_LP);
          pop1 = pop0 && (sp >= PW'(2)) && (top1 != K_LP);
          if (!pop0)      drop_lp = (sp >= PW'(1)) && (top0 == K_LP);
          else if (!pop1) drop_lp = (sp >= PW'(2)) && (top1 == K_LP);
          else            drop_lp = (sp >= PW'(3)) && (top2 == K_LP);
        end
        C_EQ:    go_flush = 1'b1;
        default: ;
      endcase
    end

    sp_pop  = sp - PW'(pop0) - PW'(pop1);
    push_wr = push_en && (sp_pop < DEPTH);

    sp_n = sp;
    if (take) begin
      if (push_wr)      sp_n = sp_pop + PW'(1);
      else if (drop_lp) sp_n = sp_pop - PW'(1);
      else              sp_n = sp_pop;
    end else if (state == S_FLUSH && sp != '0) begin
      sp_n = sp - PW'(1);
    end

    // Postfix queue writes: at most two tokens per cycle.
    qw0_en = 1'b0;
    qw1_en = 1'b0;
    qw0    = mk_num(4'd0);
    qw1    = mk_num(4'd0);
    if (wr_opnd) begin
      qw0_en = 1'b1;
      qw0    = mk_num(cval);
    end else if (pop0) begin
      qw0_en = 1'b1;
      qw0    = mk_op(top0);
      if (pop1) begin
        qw1_en = 1'b1;
        qw1    = mk_op(top1);
      end
    end
    // A '(' left over from unbalanced input is dropped during the flush.
    if (state == S_FLUSH && sp != '0 && top0 != K_LP) begin
      qw0_en = 1'b1;
      qw0    = mk_op(top0);
    end

    q1idx  = qcnt + PW'(1);
    qsum   = {1'b0, qcnt} + (PW+1)'(qw0_en) + (PW+1)'(qw1_en);
    qcnt_n = (qsum > {1'b0, DEPTH}) ? DEPTH : qsum[PW-1:0];
  end

  // Postfix evaluation
  logic                 ev_go;
  tok_t                 ev_tok;
  logic signed [DW-1:0] va, vb, alu, vs_wdat, fv;
  logic                 vs_we;
  logic [PW-1:0]        vs_widx, vsp_n;
  logic [6:0]           res_n;

  always_comb begin
    ev_go  = (state == S_EVAL) && (rp < qcnt);
    ev_tok = q[AW'(rp)];
    vb     = (vsp >= PW'(1)) ? vs[AW'(vsp - PW'(1))] : '0;
    va     = (vsp >= PW'(2)) ? vs[AW'(vsp - PW'(2))] : '0;
    fv     = vb;

    case (ev_tok.op)
      K_ADD:   alu = va + vb;
      K_SUB:   alu = va - vb;
      K_MUL:   alu = va * vb;
      default: alu = vb;
    endcase

    vs_we   = 1'b0;
    vs_widx = vsp;
    vs_wdat = '0;
    vsp_n   = vsp;
    if (ev_go) begin
      if (!ev_tok.is_op) begin
        if (vsp < DEPTH) begin
          vs_we   = 1'b1;
          vs_widx = vsp;
          vs_wdat = DW'(ev_tok.val);
          vsp_n   = vsp + PW'(1);
        end
      end else if (vsp >= PW'(2)) begin
        // Pop b, pop a, push a op b: the result overwrites a's slot.
        vs_we   = 1'b1;
        vs_widx = vsp - PW'(2);
        vs_wdat = alu;
        vsp_n   = vsp - PW'(1);
      end
    end

`ifdef AEC_SAT_EN
    if (fv[DW-1])          res_n = 7'd0;
    else if (fv > SAT_MAX) res_n = 7'd127;
    else                   res_n = fv[6:0];
`else
    res_n = fv[6:0];
`endif
  end

  // Storage arrays. Emptiness is carried by the pointers, so these need no reset.
  always_ff @(posedge clk) begin
    if (take && push_wr)
      opstk[AW'(sp_pop)] <= push_k;
    if (qw0_en && qcnt < DEPTH)
      q[AW'(qcnt)] <= qw0;
    if (qw1_en && q1idx < DEPTH)
      q[AW'(q1idx)] <= qw1;
    if (vs_we)
      vs[AW'(vs_widx)] <= vs_wdat;
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      sp     <= '0;
      qcnt   <= '0;
      rp     <= '0;
      vsp    <= '0;
      valid  <= 1'b0;
      result <= '0;
    end else begin
      valid <= 1'b0;
      sp    <= sp_n;
      qcnt  <= qcnt_n;
      case (state)
        S_IDLE: begin
          if (ready)
            state <= go_flush ? S_FLUSH : S_READ;
        end
        S_READ: begin
          if (go_flush)
            state <= S_FLUSH;
        end
        S_FLUSH: begin
          if (sp <= PW'(1))
            state <= S_EVAL;
        end
        S_EVAL: begin
          if (ev_go) begin
            rp  <= rp + PW'(1);
            vsp <= vsp_n;
          end else begin
            state <= S_OUT;
          end
        end
        S_OUT: begin
          result <= res_n;
          valid  <= 1'b1;
          state  <= S_IDLE;
          // Clear the pointers so IDLE can take the next expression immediately.
          sp     <= '0;
          qcnt   <= '0;
          rp     <= '0;
          vsp    <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aec.sv
module tb_aec;

  logic       clk = 1'b0;
  logic       rst;
  logic       ready;
  logic [7:0] ascii_in;
  logic       valid;
  logic [6:0] result;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] cq[$];

  aec #(.MAX_LEN(16), .DW(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .ready    (ready),
    .ascii_in (ascii_in),
    .valid    (valid),
    .result   (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: the true value of the expression reduced to the 7-bit output rule.
  function automatic int expect_of(input int v);
    logic signed [15:0] w;
    w = v[15:0];
`ifdef AEC_SAT_EN
    if (w < 0)        return 0;
    else if (w > 127) return 127;
    else              return int'(w);
`else
    return v & 127;
`endif
  endfunction

  function automatic logic [7:0] dchar(input int d);
    return (d < 10) ? 8'(48 + d) : 8'(87 + d);
  endfunction

  // Random expression generator. It emits characters into cq and returns the
  // exact integer value using ordinary precedence and left associativity.
  function automatic int g_digit();
    int d = int'($urandom_range(0, 15));
    if ($urandom_range(0, 9) == 0) cq.push_back(8'h20);
    cq.push_back(dchar(d));
    return d;
  endfunction

  function automatic int g_term_flat();
    int v = g_digit();
    int n = int'($urandom_range(0, 1));
    for (int i = 0; i < n; i++) begin
      cq.push_back(8'h2A);
      v = v * g_digit();
    end
    return v;
  endfunction

  function automatic int g_sum_flat();
    int v = g_term_flat();
    int n = int'($urandom_range(1, 2));
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        cq.push_back(8'h2B);
        v = v + g_term_flat();
      end else begin
        cq.push_back(8'h2D);
        v = v - g_term_flat();
      end
    end
    return v;
  endfunction

  function automatic int g_factor_nest();
    int v;
    if ($urandom_range(0, 2) == 0) begin
      cq.push_back(8'h28);
      v = g_sum_flat();
      cq.push_back(8'h29);
    end else begin
      v = g_digit();
    end
    return v;
  endfunction

  function automatic int g_term_nest();
    int v = g_factor_nest();
    int n = int'($urandom_range(0, 2));
    for (int i = 0; i < n; i++) begin
      cq.push_back(8'h2A);
      v = v * g_factor_nest();
    end
    return v;
  endfunction

  function automatic int g_sum_nest();
    int v = g_term_nest();
    int n = int'($urandom_range(0, 2));
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        cq.push_back(8'h2B);
        v = v + g_term_nest();
      end else begin
        cq.push_back(8'h2D);
        v = v - g_term_nest();
      end
    end
    return v;
  endfunction

  task automatic load(input string s);
    cq.delete();
    for (int i = 0; i < s.len(); i++) cq.push_back(s.getc(i));
  endtask

  // Entered and left just after a falling edge.
  task automatic run_expr(input string tag, input int expv);
    int lat;
    bit got;
    for (int i = 0; i < cq.size(); i++) begin
      ready    = (i == 0);
      ascii_in = cq[i];
      @(negedge clk);
    end
    ready = 1'b0;
    lat   = 0;
    got   = 1'b0;
    while (!got && lat <= 40) begin
      if (valid) got = 1'b1;
      else begin
        ascii_in = 8'($urandom);
        lat++;
        @(negedge clk);
      end
    end
    check({tag, "_valid"}, int'(got), 1);
    if (got) begin
      check({tag, "_latency"}, int'(lat <= 36), 1);
      check({tag, "_result"}, int'(result), expv);
      @(negedge clk);
      check({tag, "_pulse"}, int'(valid), 0);
    end
  endtask

  initial begin
    int seen;
    rst      = 1'b0;
    ready    = 1'b0;
    ascii_in = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_valid", int'(valid), 0);
    check("reset_result", int'(result), 0);
    rst = 1'b1;
    @(negedge clk);

    load("1+2*3=");               run_expr("prec", expect_of(7));
    load("(1+2)*3=");             run_expr("paren", expect_of(9));
    load("a*b-5=");               run_expr("b2b_hex", expect_of(105));
    load("f*f=");                 run_expr("mul_wrap", expect_of(225));
    load("2-5=");                 run_expr("neg", expect_of(-3));
    load("((9-(2+3))*(4-1))-1="); run_expr("nest", expect_of(11));
    load("8 - 3 - 2=");           run_expr("left_assoc", expect_of(3));

    // Abort an expression with reset partway through its characters.
    load("8*8+1=");
    for (int i = 0; i < 4; i++) begin
      ready    = (i == 0);
      ascii_in = cq[i];
      @(negedge clk);
    end
    ready = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    check("abort_valid", int'(valid), 0);
    check("abort_result", int'(result), 0);
    rst  = 1'b1;
    seen = 0;
    for (int i = 0; i < 45; i++) begin
      ascii_in = cq[4 + (i % 2)];
      @(negedge clk);
      if (valid) seen++;
    end
    check("abort_no_valid", seen, 0);
    load("7=");                   run_expr("after_abort", expect_of(7));

    for (int k = 0; k < 60; k++) begin
      int v;
      do begin
        cq.delete();
        v = g_sum_nest();
      end while (cq.size() > 15);
      cq.push_back(8'h3D);
      run_expr($sformatf("rand%0d", k), expect_of(v));
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          ascii_in = 8'($urandom);
          @(negedge clk);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
